// File: rtl/neuron_pkg.sv
// Shared constants, enums and Q16.16 helpers for the spiking neuron element.
package neuron_pkg;

  localparam int NUM_SYN = 4;
  localparam int FRAC    = 16;

  localparam logic [7:0] HDR_WEIGHT = 8'hFF;
  localparam logic [7:0] HDR_PARAM  = 8'hFE;
  localparam logic [7:0] HDR_MODE   = 8'hFD;

  localparam logic [2:0] SEL_A     = 3'd1;
  localparam logic [2:0] SEL_B     = 3'd2;
  localparam logic [2:0] SEL_C     = 3'd3;
  localparam logic [2:0] SEL_D     = 3'd4;
  localparam logic [2:0] SEL_VT    = 3'd5;
  localparam logic [2:0] SEL_U     = 3'd6;
  localparam logic [2:0] SEL_DECAY = 3'd7;

  typedef enum logic [1:0] {
    MODEL_LIF   = 2'b00,
    MODEL_ADAPT = 2'b01
  } model_e;

  typedef enum logic [2:0] {
    DECAY_NONE  = 3'd0,
    DECAY_SHIFT = 3'd1,
    DECAY_MUL   = 3'd7
  } decay_e;

  typedef enum logic [1:0] {
    PKT_WEIGHT,
    PKT_PARAM,
    PKT_MODE
  } pkt_e;

  function automatic logic signed [63:0] sext(input logic signed [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic signed [31:0] sat32(input logic signed [63:0] x);
    if (x > 64'sh0000_0000_7FFF_FFFF) return 32'sh7FFF_FFFF;
    else if (x < 64'shFFFF_FFFF_8000_0000) return 32'sh8000_0000;
    else return x[31:0];
  endfunction

endpackage

// File: rtl/neuron_if.sv
// Configuration byte stream, spike input and neuron outputs bundled as one bus.
interface neuron_if;

  logic        time_step;
  logic [7:0]  data;
  logic        load_data;
  logic [9:0]  src_addr_in;
  logic        spike_out;
  logic [31:0] v_mem;

  modport master (
    output time_step, data, load_data, src_addr_in,
    input  spike_out, v_mem
  );

  modport slave (
    input  time_step, data, load_data, src_addr_in,
    output spike_out, v_mem
  );

endinterface

// File: rtl/neuron_cfg_parser.sv
// Byte-serial packet parser: collects header/ctrl/payload and raises one
// commit strobe on the end byte, so nothing downstream changes mid-packet.
module neuron_cfg_parser
  import neuron_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_i,
  input  logic        load_data_i,
  output logic        commit_weight_o,
  output logic        commit_param_o,
  output logic        commit_mode_o,
  output logic [7:0]  ctrl0_o,
  output logic [9:0]  addr_o,
  output logic [31:0] value_o
);

  typedef enum logic [2:0] {S_IDLE, S_CTRL0, S_CTRL1, S_PAYLOAD, S_END} state_e;

  state_e      state_q, state_d;
  pkt_e        kind_q, kind_d;
  logic [7:0]  ctrl0_q, ctrl0_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] value_q, value_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  byte_idx;
  logic [2:0]  last_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      kind_q  <= PKT_WEIGHT;
      ctrl0_q <= '0;
      addr_q  <= '0;
      value_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      ctrl0_q <= ctrl0_d;
      addr_q  <= addr_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  // Weight payload is addr_lo, addr_hi, then value; parameter payload is value only.
  always_comb begin
    state_d         = state_q;
    kind_d          = kind_q;
    ctrl0_d         = ctrl0_q;
    addr_d          = addr_q;
    value_d         = value_q;
    cnt_d           = cnt_q;
    commit_weight_o = 1'b0;
    commit_param_o  = 1'b0;
    commit_mode_o   = 1'b0;
    byte_idx        = (kind_q == PKT_WEIGHT) ? cnt_q[1:0] - 2'd2 : cnt_q[1:0];
    last_cnt        = (kind_q == PKT_WEIGHT) ? 3'd5 : 3'd3;
    if (load_data_i) begin
      case (state_q)
        S_IDLE: begin
          cnt_d   = '0;
          state_d = S_CTRL0;
          if (data_i == HDR_WEIGHT)      kind_d = PKT_WEIGHT;
          else if (data_i == HDR_PARAM)  kind_d = PKT_PARAM;
          else if (data_i == HDR_MODE)   kind_d = PKT_MODE;
          else                           state_d = S_IDLE;
        end
        S_CTRL0: begin
          ctrl0_d = data_i;
          state_d = S_CTRL1;
        end
        S_CTRL1: state_d = (kind_q == PKT_MODE) ? S_END : S_PAYLOAD;
        S_PAYLOAD: begin
          if (kind_q == PKT_WEIGHT && cnt_q == 3'd0)      addr_d[7:0] = data_i;
          else if (kind_q == PKT_WEIGHT && cnt_q == 3'd1) addr_d[9:8] = data_i[1:0];
          else value_d[{byte_idx, 3'b000} +: 8] = data_i;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == last_cnt) state_d = S_END;
        end
        S_END: begin
          commit_weight_o = (kind_q == PKT_WEIGHT);
          commit_param_o  = (kind_q == PKT_PARAM);
          commit_mode_o   = (kind_q == PKT_MODE);
          state_d         = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ctrl0_o = ctrl0_q;
  assign addr_o  = addr_q;
  assign value_o = value_q;

endmodule

// File: rtl/neuron_unit.sv
// Spiking neuron element: weight CAM, synaptic accumulator and LIF/adaptive
// membrane update fired on each rising time_step.
module neuron_unit
  import neuron_pkg::*;
(
  input logic      clk,
  input logic      rst,
  neuron_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_SYN);

  logic        commit_weight, commit_param, commit_mode;
  logic [7:0]  cfg_ctrl0;
  logic [9:0]  cfg_addr;
  logic [31:0] cfg_value;

  neuron_cfg_parser u_parser (
    .clk             (clk),
    .rst             (rst),
    .data_i          (bus.data),
    .load_data_i     (bus.load_data),
    .commit_weight_o (commit_weight),
    .commit_param_o  (commit_param),
    .commit_mode_o   (commit_mode),
    .ctrl0_o         (cfg_ctrl0),
    .addr_o          (cfg_addr),
    .value_o         (cfg_value)
  );

  logic [9:0]         cam_addr_q [NUM_SYN];
  logic signed [31:0] cam_w_q    [NUM_SYN];
  logic [NUM_SYN-1:0] cam_valid_q;
  logic [4:0]         a_shift_q;
  logic signed [31:0] b_q, c_q, d_q, vt_q, u_q, r_q, acc_q, v_q;
  logic [2:0]         decay_q;
  logic [1:0]         model_q;
  logic               run_q, spike_q, ts_prev_q;

  logic signed [31:0] hit_w, acc_add;
  logic               wr_found;
  logic [IDX_W-1:0]   wr_idx;

  always_comb begin
    hit_w = '0;
    for (int i = 0; i < NUM_SYN; i++)
      if (cam_valid_q[i] && cam_addr_q[i] == bus.src_addr_in) hit_w = cam_w_q[i];
    acc_add = (bus.src_addr_in != '0) ? hit_w : '0;
  end

  // Lowest free slot first, then an existing entry for the same address overrides it.
  always_comb begin
    wr_found = 1'b0;
    wr_idx   = '0;
    for (int i = NUM_SYN - 1; i >= 0; i--)
      if (!cam_valid_q[i]) begin
        wr_found = 1'b1;
        wr_idx   = IDX_W'(i);
      end
    for (int i = NUM_SYN - 1; i >= 0; i--)
      if (cam_valid_q[i] && cam_addr_q[i] == cfg_addr) begin
        wr_found = 1'b1;
        wr_idx   = IDX_W'(i);
      end
  end

  logic signed [63:0] v_mul, bv_mul, bv_term;
  logic signed [31:0] dec_v, lif_v, adapt_v, u_dec, un, vn, u_fire;
  logic               adaptive, fire, step;

  always_comb begin
    v_mul = sext(v_q) * sext(r_q);
    dec_v = '0;
    case (decay_q)
      DECAY_NONE:  dec_v = v_q;
      DECAY_SHIFT: dec_v = sat32(sext(v_q) - sext(v_q >>> r_q[4:0]));
      DECAY_MUL:   dec_v = sat32(v_mul >>> FRAC);
      default:     dec_v = '0;
    endcase
    adaptive = (model_q == MODEL_ADAPT);
    lif_v    = sat32(sext(dec_v) + sext(acc_q));
    adapt_v  = sat32(sext(lif_v) - sext(u_q));
    u_dec    = sat32(sext(u_q) - sext(u_q >>> a_shift_q));
    bv_mul   = sext(b_q) * sext(v_q);
    bv_term  = (bv_mul >>> FRAC) >>> a_shift_q;
    un       = adaptive ? sat32(sext(u_dec) + bv_term) : u_q;
    vn       = adaptive ? adapt_v : lif_v;
    fire     = (vn >= vt_q);
    u_fire   = sat32(sext(un) + sext(d_q));
    step     = bus.time_step & ~ts_prev_q;
  end

  // Config commits come last so they win over a step landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SYN; i++) begin
        cam_addr_q[i] <= '0;
        cam_w_q[i]    <= '0;
      end
      cam_valid_q <= '0;
      a_shift_q   <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      vt_q        <= '0;
      u_q         <= '0;
      r_q         <= '0;
      decay_q     <= DECAY_NONE;
      model_q     <= MODEL_LIF;
      run_q       <= 1'b0;
      acc_q       <= '0;
      v_q         <= '0;
      spike_q     <= 1'b0;
      ts_prev_q   <= 1'b0;
    end else begin
      ts_prev_q <= bus.time_step;
      spike_q   <= 1'b0;
      if (run_q) begin
        if (step) begin
          acc_q   <= acc_add;
          spike_q <= fire;
          v_q     <= fire ? c_q : vn;
          u_q     <= (fire && adaptive) ? u_fire : un;
        end else begin
          acc_q <= sat32(sext(acc_q) + sext(acc_add));
        end
      end
      if (commit_weight && wr_found) begin
        cam_valid_q[wr_idx] <= 1'b1;
        cam_addr_q[wr_idx]  <= cfg_addr;
        cam_w_q[wr_idx]     <= cfg_value;
      end
      if (commit_param) begin
        case (cfg_ctrl0[5:3])
          SEL_A:  a_shift_q <= cfg_value[4:0];
          SEL_B:  b_q       <= cfg_value;
          SEL_C:  c_q       <= cfg_value;
          SEL_D:  d_q       <= cfg_value;
          SEL_VT: vt_q      <= cfg_value;
          SEL_U:  u_q       <= cfg_value;
          SEL_DECAY: begin
            r_q     <= cfg_value;
            decay_q <= cfg_ctrl0[2:0];
          end
          default: ;
        endcase
      end
      if (commit_mode) begin
        run_q   <= cfg_ctrl0[0];
        model_q <= cfg_ctrl0[7:6];
      end
    end
  end

  assign bus.spike_out = spike_q;
  assign bus.v_mem     = v_q;

endmodule

// File: tb/tb_neuron_unit.sv
// Directed bench for neuron_unit: packet-level reference model compared every
// cycle, plus literal checkpoints for the key scenarios.
module tb_neuron_unit;

  logic clk = 1'b0;
  logic rst;
  neuron_if bus ();

  neuron_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit modelOn = 1'b0;

  int  mAddr [4];
  int  mWt   [4];
  bit  mValid[4];
  int  mA, mB, mC, mD, mVT, mU, mR, mV, mAcc, mDecay, mModel;
  bit  mRun, mSpike, mPrevTs;
  logic [7:0] pkt[$];

  function automatic int sat(input longint x);
    if (x > 64'sh7FFFFFFF) return int'(32'h7FFFFFFF);
    if (x < -64'sh80000000) return int'(32'h80000000);
    return int'(x);
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 4; i++) begin
      mAddr[i] = 0; mWt[i] = 0; mValid[i] = 0;
    end
    mA = 0; mB = 0; mC = 0; mD = 0; mVT = 0; mU = 0; mR = 0; mV = 0; mAcc = 0;
    mDecay = 0; mModel = 0; mRun = 0; mSpike = 0; mPrevTs = 0;
    pkt.delete();
  endtask

  task automatic modelCommitWeight(input int addr, input int val);
    int idx = -1;
    for (int i = 0; i < 4; i++) if (idx < 0 && mValid[i] && mAddr[i] == addr) idx = i;
    for (int i = 0; i < 4; i++) if (idx < 0 && !mValid[i]) idx = i;
    if (idx >= 0) begin
      mValid[idx] = 1; mAddr[idx] = addr; mWt[idx] = val;
    end
  endtask

  task automatic modelByte(input logic [7:0] b);
    int need;
    logic [7:0] c0, lo, hi;
    if (pkt.size() == 0) begin
      if (b == 8'hFF || b == 8'hFE || b == 8'hFD) pkt.push_back(b);
      return;
    end
    pkt.push_back(b);
    need = (pkt[0] == 8'hFF) ? 10 : (pkt[0] == 8'hFE) ? 8 : 4;
    if (pkt.size() < need) return;
    c0 = pkt[1];
    if (pkt[0] == 8'hFF) begin
      lo = pkt[3]; hi = pkt[4];
      modelCommitWeight(int'({22'd0, hi[1:0], lo}), int'({pkt[8], pkt[7], pkt[6], pkt[5]}));
    end else if (pkt[0] == 8'hFE) begin
      case (c0[5:3])
        3'd1: mA  = int'({pkt[6], pkt[5], pkt[4], pkt[3]});
        3'd2: mB  = int'({pkt[6], pkt[5], pkt[4], pkt[3]});
        3'd3: mC  = int'({pkt[6], pkt[5], pkt[4], pkt[3]});
        3'd4: mD  = int'({pkt[6], pkt[5], pkt[4], pkt[3]});
        3'd5: mVT = int'({pkt[6], pkt[5], pkt[4], pkt[3]});
        3'd6: mU  = int'({pkt[6], pkt[5], pkt[4], pkt[3]});
        3'd7: begin
          mR = int'({pkt[6], pkt[5], pkt[4], pkt[3]});
          mDecay = int'(c0[2:0]);
        end
        default: ;
      endcase
    end else begin
      mRun = c0[0];
      mModel = int'(c0[7:6]);
    end
    pkt.delete();
  endtask

  task automatic modelStep();
    longint v = mV, u = mU, dec, vn, un;
    int sh = mA & 31;
    case (mDecay)
      0: dec = v;
      1: dec = sat(v - (v >>> (mR & 31)));
      7: dec = sat((v * longint'(mR)) >>> 16);
      default: dec = 0;
    endcase
    vn = sat(dec + mAcc);
    un = u;
    if (mModel == 1) begin
      vn = sat(vn - u);
      un = sat(sat(u - (u >>> sh)) + (((longint'(mB) * v) >>> 16) >>> sh));
    end
    if (vn >= mVT) begin
      mSpike = 1;
      mV = mC;
      mU = (mModel == 1) ? sat(un + mD) : int'(un);
    end else begin
      mV = int'(vn);
      mU = int'(un);
    end
  endtask

  always @(posedge clk) begin : modelProc
    int w;
    bit stp;
    if (rst) begin
      modelClear();
    end else begin
      stp = bus.time_step && !mPrevTs;
      mPrevTs = bus.time_step;
      mSpike = 0;
      w = 0;
      if (bus.src_addr_in != 0)
        for (int i = 0; i < 4; i++)
          if (mValid[i] && mAddr[i] == int'(bus.src_addr_in)) w = mWt[i];
      if (mRun) begin
        if (stp) begin
          modelStep();
          mAcc = w;
        end else begin
          mAcc = sat(longint'(mAcc) + w);
        end
      end
      if (bus.load_data) modelByte(bus.data);
    end
  end

  always @(negedge clk) begin
    if (modelOn) begin
      checks++;
      if (bus.v_mem !== mV) begin
        errors++;
        $display("[TB] FAIL model v_mem @%0t: got %h expected %h", $time, bus.v_mem, mV);
      end
      checks++;
      if (bus.spike_out !== mSpike) begin
        errors++;
        $display("[TB] FAIL model spike_out @%0t: got %b expected %b", $time, bus.spike_out, mSpike);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] d, input logic ld, input logic [9:0] src, input logic ts);
    @(negedge clk);
    bus.data = d;
    bus.load_data = ld;
    bus.src_addr_in = src;
    bus.time_step = ts;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expV, input logic expS);
    checks++;
    if (bus.v_mem !== expV) begin
      errors++;
      $display("[TB] FAIL %s v_mem: got %h expected %h", name, bus.v_mem, expV);
    end
    checks++;
    if (bus.spike_out !== expS) begin
      errors++;
      $display("[TB] FAIL %s spike_out: got %b expected %b", name, bus.spike_out, expS);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(b, 1'b1, 10'd0, 1'b0);
  endtask

  task automatic sendWeight(input logic [9:0] a, input logic [31:0] v);
    sendByte(8'hFF); sendByte(8'h00); sendByte(8'h00);
    sendByte(a[7:0]); sendByte({6'd0, a[9:8]});
    sendByte(v[7:0]); sendByte(v[15:8]); sendByte(v[23:16]); sendByte(v[31:24]);
    sendByte(8'h00);
  endtask

  task automatic sendParam(input logic [2:0] sel, input logic [2:0] dm, input logic [31:0] v);
    sendByte(8'hFE); sendByte({2'b00, sel, dm}); sendByte(8'h00);
    sendByte(v[7:0]); sendByte(v[15:8]); sendByte(v[23:16]); sendByte(v[31:24]);
    sendByte(8'h00);
  endtask

  task automatic sendMode(input logic [7:0] m);
    sendByte(8'hFD); sendByte(m); sendByte(8'h00); sendByte(8'h00);
  endtask

  task automatic spike(input logic [9:0] a);
    applyStimulus(8'h00, 1'b0, a, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(8'h00, 1'b0, 10'd0, 1'b0);
  endtask

  task automatic step();
    applyStimulus(8'h00, 1'b0, 10'd0, 1'b1);
    idle();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    bus.data = 8'h00; bus.load_data = 1'b0; bus.src_addr_in = 10'd0; bus.time_step = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish expected finish within budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    bus.data = 8'h00; bus.load_data = 1'b0; bus.src_addr_in = 10'd0; bus.time_step = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelOn = 1'b1;
    checkOutput("reset", 32'h0, 1'b0);

    // Three weights summed in one step cross the threshold.
    sendWeight(10'd1, 32'h00050403);
    sendWeight(10'd2, 32'h00000403);
    sendWeight(10'd3, 32'h01000403);
    sendParam(3'd5, 3'd0, 32'h005B02AF);
    sendParam(3'd3, 3'd0, 32'h240322AF);
    sendMode(8'h01);
    spike(10'd1); spike(10'd2); spike(10'd3);
    step();
    checkOutput("fire", 32'h240322AF, 1'b1);
    idle();
    checkOutput("spike_one_cycle", 32'h240322AF, 1'b0);

    doReset();
    sendWeight(10'd1, 32'h00050403);
    sendWeight(10'd3, 32'h01000403);
    sendParam(3'd5, 3'd0, 32'h7FFFFFFF);
    sendMode(8'h01);
    spike(10'd1); spike(10'd3);
    step();
    checkOutput("lif_accum", 32'h01050806, 1'b0);
    step();
    checkOutput("no_input_hold", 32'h01050806, 1'b0);
    applyStimulus(8'h00, 1'b0, 10'd1, 1'b1);
    applyStimulus(8'h00, 1'b0, 10'd0, 1'b1);
    applyStimulus(8'h00, 1'b0, 10'd0, 1'b1);
    idle();
    checkOutput("held_step_once", 32'h01050806, 1'b0);
    step();
    checkOutput("edge_spike_next", 32'h010A0C09, 1'b0);
    sendMode(8'h00);
    spike(10'd1);
    step();
    sendMode(8'h01);
    step();
    checkOutput("run_off", 32'h010A0C09, 1'b0);

    doReset();
    sendWeight(10'd5, 32'h00010000);
    sendParam(3'd5, 3'd0, 32'h7FFFFFFF);
    sendMode(8'h01);
    spike(10'd5);
    step();
    checkOutput("decay_setup", 32'h00010000, 1'b0);
    sendParam(3'd7, 3'd1, 32'd15);
    step();
    checkOutput("decay_shift", 32'h0000FFFE, 1'b0);
    sendParam(3'd7, 3'd7, 32'h00008000);
    step();
    checkOutput("decay_mul", 32'h00007FFF, 1'b0);

    doReset();
    sendParam(3'd5, 3'd0, 32'h7FFFFFFF);
    sendMode(8'h01);
    sendWeight(10'd1, 32'h00000005);
    sendWeight(10'd1, 32'h00000010);
    spike(10'd1);
    step();
    checkOutput("overwrite", 32'h00000010, 1'b0);
    sendWeight(10'd2, 32'h00000100);
    sendWeight(10'd3, 32'h00001000);
    sendWeight(10'd4, 32'h00010000);
    sendWeight(10'd6, 32'h00000007);
    spike(10'd4); spike(10'd6);
    step();
    checkOutput("cam_full_drop", 32'h00010010, 1'b0);
    spike(10'd2); spike(10'd3);
    step();
    checkOutput("cam_entries", 32'h00011110, 1'b0);

    doReset();
    sendByte(8'hAA);
    sendMode(8'h01);
    sendParam(3'd5, 3'd0, 32'h7FFFFFFF);
    sendWeight(10'd1, 32'h00000020);
    spike(10'd1);
    step();
    checkOutput("bad_header", 32'h00000020, 1'b0);
    sendByte(8'hFF); sendByte(8'h00); sendByte(8'h00);
    doReset();
    checkOutput("abort_reset", 32'h0, 1'b0);
    sendMode(8'h01);
    sendParam(3'd5, 3'd0, 32'h7FFFFFFF);
    sendWeight(10'd1, 32'h00000030);
    spike(10'd1);
    step();
    checkOutput("after_abort", 32'h00000030, 1'b0);

    // Two consecutive spikes of 0x40000000 saturate the accumulator at the max threshold.
    doReset();
    sendWeight(10'd1, 32'h40000000);
    sendParam(3'd5, 3'd0, 32'h7FFFFFFF);
    sendParam(3'd3, 3'd0, 32'h00001234);
    sendMode(8'h01);
    spike(10'd1); spike(10'd1);
    step();
    checkOutput("saturate_fire", 32'h00001234, 1'b1);

    doReset();
    sendWeight(10'd1, 32'h00050403);
    sendParam(3'd5, 3'd0, 32'h00050000);
    sendParam(3'd3, 3'd0, 32'h00020000);
    sendParam(3'd4, 3'd0, 32'h00010000);
    sendParam(3'd1, 3'd0, 32'h0000001F);
    sendMode(8'h41);
    spike(10'd1);
    step();
    checkOutput("adapt_fire", 32'h00020000, 1'b1);
    step();
    checkOutput("adapt_sub_u", 32'h00010000, 1'b0);
    step();
    checkOutput("adapt_sub_u2", 32'h00000000, 1'b0);
    sendParam(3'd2, 3'd0, 32'h00010000);
    sendParam(3'd6, 3'd0, 32'h00000100);
    spike(10'd1);
    step();
    idle();
    step();
    idle();

    modelOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
